// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive/transmit controllers.
package uart_pkg;

    // Character-timeout sequencer states.
    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_COUNT   = 2'd1,
        T_EXPIRED = 2'd2
    } to_state_e;

    // Trigger-level select encoding.
    localparam logic [1:0] TRIG_ONE       = 2'b00;
    localparam logic [1:0] TRIG_QUARTER   = 2'b01;
    localparam logic [1:0] TRIG_HALF      = 2'b10;
    localparam logic [1:0] TRIG_NEAR_FULL = 2'b11;

    // Start + 8 data + stop.
    localparam int unsigned CHAR_BITS = 10;

    // Map a trigger select onto an absolute fill level for a FIFO of the given depth.
    function automatic int unsigned trig_level(input logic [1:0] sel, input int unsigned depth);
        int unsigned lvl;
        lvl = 1;
        case (sel)
            TRIG_ONE:       lvl = 1;
            TRIG_QUARTER:   lvl = depth / 4;
            TRIG_HALF:      lvl = depth / 2;
            TRIG_NEAR_FULL: lvl = depth - 2;
            default:        lvl = 1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous show-ahead FIFO with clear. Head entry is combinational on data_o.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    elements_o,
    output logic [CW-1:0]    elements_nxt_o
);

    logic [AW-1:0]    wptr_d, wptr_q;
    logic [AW-1:0]    rptr_d, rptr_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_acc;
    logic             pop_acc;

    assign empty_o        = (cnt_q == '0);
    assign full_o         = (cnt_q == CW'(DEPTH));
    assign elements_o     = cnt_q;
    assign elements_nxt_o = cnt_d;
    assign data_o         = empty_o ? '0 : mem_q[rptr_q];

    assign pop_acc  = pop_i & ~empty_o;
    assign push_acc = push_i & (~full_o | pop_acc);

    // Pointer and fill-count next state; clear overrides any traffic.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_acc) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop_acc) begin
                rptr_d = rptr_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(push_acc) - CW'(pop_acc);
        end
    end

    // Storage write: only accepted pushes land in the array.
    always_comb begin
        mem_d = mem_q;
        if (push_acc && !clr_i) begin
            mem_d[wptr_q] = data_i;
        end
    end

    // Control state, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array, no reset needed since empty entries are never exposed.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: buffers every received character, tracks overrun,
// and raises trigger-level and character-timeout interrupts. Never stalls the receiver.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 16,
    parameter  int unsigned TO_BITS    = 4 * CHAR_BITS,
    localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned TW         = $clog2(TO_BITS + 1)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          cfg_en_i,
    input  logic [15:0]   cfg_div_i,
    input  logic [1:0]    cfg_trig_i,
    input  logic          fifo_clr_i,
    input  logic          uart_valid_i,
    input  logic [7:0]    uart_data_i,
    input  logic          uart_busy_i,
    output logic          uart_ready_o,
    output logic          rd_valid_o,
    output logic [7:0]    rd_data_o,
    input  logic          rd_ready_i,
    output logic [CW-1:0] elements_o,
    output logic          irq_trig_o,
    output logic          irq_timeout_o,
    output logic          overrun_o,
    input  logic          overrun_clr_i
);

    logic          flush;
    logic          push;
    logic          pop;
    logic          restart;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] elements_nxt;
    logic [CW-1:0] trig_lvl;
    logic          bit_tick;

    to_state_e     state_d, state_q;
    logic [TW-1:0] to_cnt_d, to_cnt_q;
    logic [15:0]   bit_cnt_d, bit_cnt_q;
    logic          overrun_d, overrun_q;
    logic          irq_trig_d, irq_trig_q;
    logic          irq_timeout_d, irq_timeout_q;

    // The receiver is never back-pressured; overflow is handled by dropping.
    assign uart_ready_o = 1'b1;

    assign flush      = fifo_clr_i | ~cfg_en_i;
    assign push       = uart_valid_i & cfg_en_i & ~fifo_clr_i;
    assign rd_valid_o = ~fifo_empty;
    assign pop        = rd_valid_o & rd_ready_i;
    assign restart    = push | pop | uart_busy_i | flush;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .clr_i          (flush),
        .push_i         (push),
        .data_i         (uart_data_i),
        .pop_i          (pop),
        .data_o         (rd_data_o),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty),
        .elements_o     (elements_o),
        .elements_nxt_o (elements_nxt)
    );

    // Sticky overrun: a same-cycle clear beats a new drop.
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end else if (push && fifo_full && !pop) begin
            overrun_d = 1'b1;
        end
    end

    // Trigger interrupt follows the fill level the FIFO will hold next cycle.
    always_comb begin
        trig_lvl   = CW'(trig_level(cfg_trig_i, FIFO_DEPTH));
        irq_trig_d = (elements_nxt >= trig_lvl);
    end

    assign bit_tick = (state_q == T_COUNT) && (bit_cnt_q == cfg_div_i);

    // Timeout sequencer: counts idle bit periods while data sits unread.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = '0;
        unique case (state_q)
            T_IDLE: begin
                to_cnt_d = '0;
                if (!fifo_empty && !restart) begin
                    state_d = T_COUNT;
                end
            end
            T_COUNT: begin
                if (flush || (elements_nxt == '0)) begin
                    state_d  = T_IDLE;
                    to_cnt_d = '0;
                end else if (restart) begin
                    to_cnt_d = '0;
                end else if (bit_tick) begin
                    // to_cnt tops out at TO_BITS, so it never wraps.
                    if (to_cnt_q == TW'(TO_BITS - 1)) begin
                        state_d = T_EXPIRED;
                    end
                    to_cnt_d = to_cnt_q + TW'(1);
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            T_EXPIRED: begin
                // Receiver activity alone is not enough to acknowledge a timeout.
                if (flush || (elements_nxt == '0)) begin
                    state_d  = T_IDLE;
                    to_cnt_d = '0;
                end else if (push || pop) begin
                    state_d  = T_COUNT;
                    to_cnt_d = '0;
                end
            end
            default: begin
                state_d  = T_IDLE;
                to_cnt_d = '0;
            end
        endcase
        irq_timeout_d = (state_d == T_EXPIRED);
    end

    // Controller state and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q       <= T_IDLE;
            to_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            overrun_q     <= 1'b0;
            irq_trig_q    <= 1'b0;
            irq_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            overrun_q     <= overrun_d;
            irq_trig_q    <= irq_trig_d;
            irq_timeout_q <= irq_timeout_d;
        end
    end

    assign overrun_o     = overrun_q;
    assign irq_trig_o    = irq_trig_q;
    assign irq_timeout_o = irq_timeout_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: queue-based reference model plus a pop monitor.
module tb_uart_rx_ctrl;

    localparam int D  = 16;
    localparam int CW = $clog2(D) + 1;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          cfg_en_i;
    logic [15:0]   cfg_div_i;
    logic [1:0]    cfg_trig_i;
    logic          fifo_clr_i;
    logic          uart_valid_i;
    logic [7:0]    uart_data_i;
    logic          uart_busy_i;
    logic          uart_ready_o;
    logic          rd_valid_o;
    logic [7:0]    rd_data_o;
    logic          rd_ready_i;
    logic [CW-1:0] elements_o;
    logic          irq_trig_o;
    logic          irq_timeout_o;
    logic          overrun_o;
    logic          overrun_clr_i;

    always #5 clk_i = ~clk_i;

    uart_rx_ctrl #(
        .FIFO_DEPTH (D),
        .TO_BITS    (40)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .cfg_en_i      (cfg_en_i),
        .cfg_div_i     (cfg_div_i),
        .cfg_trig_i    (cfg_trig_i),
        .fifo_clr_i    (fifo_clr_i),
        .uart_valid_i  (uart_valid_i),
        .uart_data_i   (uart_data_i),
        .uart_busy_i   (uart_busy_i),
        .uart_ready_o  (uart_ready_o),
        .rd_valid_o    (rd_valid_o),
        .rd_data_o     (rd_data_o),
        .rd_ready_i    (rd_ready_i),
        .elements_o    (elements_o),
        .irq_trig_o    (irq_trig_o),
        .irq_timeout_o (irq_timeout_o),
        .overrun_o     (overrun_o),
        .overrun_clr_i (overrun_clr_i)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         mcnt = 0;
    bit         movr = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lvl(input logic [1:0] t);
        case (t)
            2'b00:   return 1;
            2'b01:   return D / 4;
            2'b10:   return D / 2;
            default: return D - 2;
        endcase
    endfunction

    // One clock of stimulus: update the model from the spec rules, then check after the edge.
    task automatic cyc(input bit v, input logic [7:0] d, input bit rdy, input bit clr,
                       input bit oclr, input bit busy);
        bit flush, do_push, do_pop, acc;
        uart_valid_i  = v;
        uart_data_i   = d;
        rd_ready_i    = rdy;
        fifo_clr_i    = clr;
        overrun_clr_i = oclr;
        uart_busy_i   = busy;
        flush   = clr || !cfg_en_i;
        do_push = v && cfg_en_i && !clr;
        do_pop  = (mcnt > 0) && rdy;
        acc     = do_push && ((mcnt < D) || do_pop);
        if (acc) exp_q.push_back(d);
        if (oclr) movr = 1'b0;
        else if (do_push && (mcnt == D) && !do_pop) movr = 1'b1;
        if (flush) mcnt = 0;
        else mcnt = mcnt + int'(acc) - int'(do_pop);
        @(posedge clk_i);
        #1;
        if (flush) exp_q.delete();
        chk("elements", int'(elements_o), mcnt);
        chk("rd_valid", int'(rd_valid_o), int'(mcnt != 0));
        chk("overrun", int'(overrun_o), int'(movr));
        chk("irq_trig", int'(irq_trig_o), int'(mcnt >= lvl(cfg_trig_i)));
        if (mcnt == 0) chk("rd_data_empty", int'(rd_data_o), 0);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every accepted pop must present the oldest expected character.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk_i);
            if (rstn_i && rd_valid_o && rd_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_data: pop of 0x%0h with nothing expected at %0t",
                             rd_data_o, $time);
                end else begin
                    exp = exp_q.pop_front();
                    chk("pop_data", int'(rd_data_o), int'(exp));
                end
            end
        end
    end

    initial begin
        rstn_i        = 1'b0;
        cfg_en_i      = 1'b1;
        cfg_div_i     = 16'hFFFF;
        cfg_trig_i    = 2'b00;
        fifo_clr_i    = 1'b0;
        uart_valid_i  = 1'b1;
        uart_data_i   = 8'h5A;
        uart_busy_i   = 1'b0;
        rd_ready_i    = 1'b0;
        overrun_clr_i = 1'b0;

        // Reset held two cycles with a character offered.
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_elements", int'(elements_o), 0);
        chk("rst_rd_valid", int'(rd_valid_o), 0);
        chk("rst_rd_data", int'(rd_data_o), 0);
        chk("rst_irq_trig", int'(irq_trig_o), 0);
        chk("rst_irq_timeout", int'(irq_timeout_o), 0);
        chk("rst_overrun", int'(overrun_o), 0);
        chk("uart_ready", int'(uart_ready_o), 1);
        rstn_i       = 1'b1;
        uart_valid_i = 1'b0;

        // Two pushes then two pops.
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("head_a5", int'(rd_data_o), 8'hA5);
        cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("head_3c", int'(rd_data_o), 8'h3C);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Trigger at half full.
        cfg_trig_i = 2'b10;
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("trig_at_8", int'(irq_trig_o), 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("trig_after_pop", int'(irq_trig_o), 0);
        cfg_trig_i = 2'b11;
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Fill, overflow, push+pop while full, overrun clear racing an overflow.
        for (int i = 0; i < D; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_head_kept", int'(rd_data_o), 8'h40);
        chk("ovf_flag", int'(overrun_o), 1);
        cyc(1'b1, 8'h88, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("full_pushpop_cnt", int'(elements_o), D);
        cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_clr_wins", int'(overrun_o), 0);
        cyc(1'b1, 8'h9A, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("flush_keeps_ovr", int'(overrun_o), 1);

        // Timeout latency with cfg_div = 3: 40 * 4 + 1 = 161 cycles after the push.
        cfg_div_i = 16'd3;
        cyc(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 165; k++) begin
            idle();
            chk("timeout_latency", int'(irq_timeout_o), int'(k >= 161));
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("timeout_clr_by_pop", int'(irq_timeout_o), 0);

        // Periodic receiver activity keeps restarting the timer.
        cyc(1'b1, 8'hD4, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 400; k++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, (k % 100) == 0);
            chk("timeout_busy", int'(irq_timeout_o), 0);
        end
        for (int k = 0; k < 50; k++) idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("midcount_flush_ovr", int'(overrun_o), 1);
        for (int k = 0; k < 200; k++) begin
            idle();
            chk("timeout_after_flush", int'(irq_timeout_o), 0);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic, alternating fill-heavy and drain-heavy phases.
        cfg_div_i = 16'd2000;
        for (int ph = 0; ph < 6; ph++) begin
            for (int k = 0; k < 500; k++) begin
                bit v, rdy, clr, oclr, busy;
                v    = ($urandom_range(0, 3) != 0);
                rdy  = (ph % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                clr  = ($urandom_range(0, 149) == 0);
                oclr = ($urandom_range(0, 49) == 0);
                busy = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 63) == 0) cfg_trig_i = 2'($urandom_range(0, 3));
                cfg_en_i = ($urandom_range(0, 199) != 0);
                cyc(v, 8'($urandom), rdy, clr, oclr, busy);
            end
        end
        cfg_en_i = 1'b1;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
